dmem_arbiter: RTL

//  Two-requester arbiter sharing the single-ported data memory of the SIMD core.

---
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the SIMD core data RAM: core MEM stage (port 0) vs DMA (port 1).
// Round-robin on conflict, DMA burst lock bounded by a watchdog, tagged read returns.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          stall0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

    typedef enum logic [1:0] {
        S_OPEN,
        S_LOCKED,
        S_FORCE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last;
    logic            w_last_nxt;
    logic [CW-1:0]   r_lock_cnt;
    logic [CW-1:0]   w_lock_cnt_nxt;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_push_vld;
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_port;

    // r_last holds the port that won the most recent conflict; the other port wins the next one.
    always_comb begin
        w_gnt0         = 1'b0;
        w_gnt1         = 1'b0;
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            S_OPEN: begin
                if (req0 && req1) begin
                    w_gnt0     = r_last;
                    w_gnt1     = ~r_last;
                    w_last_nxt = ~r_last;
                end else begin
                    w_gnt0 = req0;
                    w_gnt1 = req1;
                end
                if (w_gnt1 && lock1) begin
                    w_state_nxt    = S_LOCKED;
                    w_lock_cnt_nxt = CW'(1);
                end
            end
            S_LOCKED: begin
                w_gnt1         = req1;
                w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                if (!lock1) begin
                    w_state_nxt = S_OPEN;
                end else if (w_lock_cnt_nxt == LOCK_MAX_C) begin
                    w_state_nxt = S_FORCE;
                end
            end
            S_FORCE: begin
                w_gnt0         = req0;
                w_gnt1         = req1 & ~req0;
                w_state_nxt    = S_OPEN;
                w_lock_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = S_OPEN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_OPEN;
            r_last     <= 1'b1;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    assign gnt0   = w_gnt0;
    assign gnt1   = w_gnt1;
    assign stall0 = req0 & ~w_gnt0;

    always_comb begin
        mem_en    = w_gnt0 | w_gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (w_gnt1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    // Tag pipeline mirrors the RAM read latency; the tail entry owns the current mem_rdata.
    assign w_push_vld = (w_gnt0 & ~we0) | (w_gnt1 & ~we1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_vld  <= '0;
            r_tag_port <= '0;
        end else begin
            r_tag_vld[0]  <= w_push_vld;
            r_tag_port[0] <= w_gnt1;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_port[i] <= r_tag_port[i-1];
            end
        end
    end

    assign rvalid0 = r_tag_vld[RD_LAT-1] & ~r_tag_port[RD_LAT-1];
    assign rvalid1 = r_tag_vld[RD_LAT-1] &  r_tag_port[RD_LAT-1];
    assign rdata0  = rvalid0 ? mem_rdata : '0;
    assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule
